// File: rtl/shift_pkg.sv
// Shared encodings for the shift-register transmitter: FSM states and
// the mode codes that steer the universal shift register.
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_LOAD = 2'd1,
    MODE_SHL  = 2'd2,
    MODE_SHR  = 2'd3
  } mode_t;

endpackage

// File: rtl/shift_reg_universal.sv
// Universal shift register: hold, parallel load, or shift one position
// left/right with zero fill at the vacated end.
module shift_reg_universal
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next register contents selected by the mode code.
  always_comb begin
    q_d = q_q;
    case (mode)
      MODE_HOLD: q_d = q_q;
      MODE_LOAD: q_d = d;
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], 1'b0};
      MODE_SHR:  q_d = {1'b0, q_q[WIDTH-1:1]};
      default:   q_d = q_q;
    endcase
  end

  // Register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/shift_reg_ctrl.sv
// Handshaked parallel-to-serial transmitter: accepts a word, shifts it out
// one bit per serial transfer in the latched direction, then pulses done.
module shift_reg_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  input  logic             msb_first,
  output logic             so,
  output logic             so_valid,
  input  logic             so_ready,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             msb_q, msb_d;
  mode_t            mode;

  shift_reg_universal #(
    .WIDTH (WIDTH)
  ) u_sreg (
    .clk     (clk),
    .reset_n (reset_n),
    .mode    (mode),
    .d       (d),
    .q       (q)
  );

  // Next-state, counter, direction latch and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    msb_d    = msb_q;
    mode     = MODE_HOLD;
    in_ready = 1'b0;
    so_valid = 1'b0;
    so       = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = reset_n;
        if (in_valid && reset_n) begin
          mode    = MODE_LOAD;
          msb_d   = msb_first;
          cnt_d   = CNT_MAX;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        so_valid = 1'b1;
        busy     = 1'b1;
        so       = msb_q ? q[WIDTH-1] : q[0];
        if (so_ready) begin
          mode = msb_q ? MODE_SHL : MODE_SHR;
          // Exit at zero so the counter never wraps.
          if (cnt_q == '0) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else begin
          mode = MODE_HOLD;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        in_ready = reset_n;
        if (in_valid && reset_n) begin
          mode    = MODE_LOAD;
          msb_d   = msb_first;
          cnt_d   = CNT_MAX;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and direction registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      msb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msb_q   <= msb_d;
    end
  end

endmodule

// File: doc/shift_reg_ctrl.md
# shift_reg_ctrl

Sequencing controller that turns the parallel shift-register datapath into a handshaked parallel-to-serial transmitter. It accepts a WIDTH-bit word over a valid/ready interface, loads it into an internal universal shift register, and shifts it out one bit per accepted serial transfer, MSB-first or LSB-first. It honours downstream backpressure and pulses `done` after the last bit. It sits between a parallel word producer and a bit-serial consumer in the sequential-design blocks.

## Interface
- `WIDTH`, default 4: word width in bits, minimum 2.
- `CNT_W`, default derived as clog2(WIDTH): bit-counter width (localparam, not overridable).

- `clk`  in  1  sole clock, rising-edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  in  1  producer has a word on `d`.
- `in_ready`  out  1  controller can accept a word this cycle.
- `d`  in  WIDTH  parallel word; sampled when `in_valid && in_ready`.
- `msb_first`  in  1  shift direction; sampled together with `d`.
- `so`  out  1  current serial bit.
- `so_valid`  out  1  `so` is valid.
- `so_ready`  in  1  consumer accepts `so` this cycle.
- `q`  out  WIDTH  live parallel view of the shift register.
- `busy`  out  1  high in SHIFT.
- `done`  out  1  one-cycle pulse after the last bit transfers.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE:**
  - `in_ready`=1, `so_valid`=0, `so`=0.
  - On accept: load `d` into the register and latch `msb_first`.
  - Set the counter to WIDTH-1, then go to SHIFT.
- **SHIFT:**
  - `in_ready`=0, `so_valid`=1, `busy`=1.
  - `so` is `q[WIDTH-1]` when msb_first, otherwise `q[0]`.
  - On a transfer (`so_valid && so_ready`): shift one position toward the output end, zero-fill the vacated end, and decrement the counter.
  - A transfer with counter==0 moves the FSM to DONE.
  - With `so_ready`=0: the register, counter and `so` hold.
- **DONE:**
  - `done`=1, `so_valid`=0, `in_ready`=1.
  - An accept in this cycle loads the new word and goes directly to SHIFT (back-to-back).
  - Otherwise the FSM goes to IDLE.
- `in_valid` during SHIFT is ignored. `d` and `msb_first` changes during SHIFT have no effect.
- Counter arithmetic is unsigned CNT_W bits. The counter never wraps, because the SHIFT exit happens at 0.
- **Reset:**
  - `reset_n` low at any edge, including mid-shift, forces IDLE and clears `q` and the counter to 0.
  - Outputs after that edge: `in_ready`=1, `so`=0, `so_valid`=0, `busy`=0, `done`=0. The partial word is discarded.
  - While `reset_n` is low, `in_ready` is gated to 0.

## Timing
- Accept at edge N gives first bit valid in cycle N+1 (latency 1).
- With `so_ready` held high:
  - bits occupy cycles N+1..N+WIDTH;
  - `done` is asserted in cycle N+WIDTH+1.
- Back-to-back throughput is one word per WIDTH+1 cycles.
- Each low cycle of `so_ready` in SHIFT stretches the sequence by exactly one cycle.
- `done`, `busy`, `so_valid` and `in_ready` decode from registered state only; none depends combinationally on `so_ready`.
- `in_ready` additionally depends on `reset_n`.

## Structure
- Shared package `shift_pkg`:
  - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - shift-register mode codes MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR.
- Sub-module `shift_reg_universal` (WIDTH, clk, reset_n, mode, d, q): load, shift left, shift right or hold, with zero fill.
- The controller holds the FSM, the counter and the direction latch, and drives `mode`.

## Test plan
- Reset mid-shift: load 4'b1011, hold `reset_n`=0 for 2 edges after the 2nd bit -> `q`=0, `so_valid`=0, `busy`=0, `done`=0, `in_ready`=1 after release.
- MSB-first: accept 4'b1011, msb_first=1, `so_ready`=1 -> `so`=1,0,1,1 in cycles N+1..N+4, `done`=1 only in N+5.
- LSB-first: accept 4'b1011, msb_first=0 -> `so`=1,1,0,1, `done` in N+5.
- Backpressure: 4'b1011 MSB-first, `so_ready`=0 for 3 cycles after the 2nd bit -> `so` holds 1 (3rd bit) with `q` unchanged, `done` in N+8.
- Back-to-back: `in_valid` held, 4'hA then 4'h5, MSB-first -> `so`=1,0,1,0, second accept in the `done` cycle, then `so`=0,1,0,1, period 5 cycles.
- Ignore during shift: drive `in_valid`=1 with `d`=4'hF mid-shift of 4'h0 -> `in_ready`=0, output stays 0,0,0,0, 4'hF accepted only in the DONE cycle.
